// File: rtl/cpu_bringup_harness_if.sv
// Bus bundle between the cpu core (or a bench acting as the core) and the bring-up harness.
// The master drives fetch/data/load requests; the slave returns memory data and test status.
interface cpu_bringup_harness_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] iaddr;
  logic [XLEN-1:0] idata;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            wr;
  logic [XLEN-1:0] data;
  logic            ld_en;
  logic [XLEN-1:0] ld_addr;
  logic [XLEN-1:0] ld_data;
  logic            done;
  logic            pass;
  logic [XLEN-2:0] fail_code;
  logic            timeout;
  logic            addr_err;
  logic [31:0]     cycles;

  modport master (
    output iaddr, addr, wdata, wr, ld_en, ld_addr, ld_data,
    input  idata, data, done, pass, fail_code, timeout, addr_err, cycles
  );

  modport slave (
    input  iaddr, addr, wdata, wr, ld_en, ld_addr, ld_data,
    output idata, data, done, pass, fail_code, timeout, addr_err, cycles
  );
endinterface

// File: rtl/cpu_bringup_harness.sv
// Bring-up harness for the cpu core: instruction/data memories, core reset sequencing,
// program load while the core is held, and end-of-test detection via tohost or timeout.
module cpu_bringup_harness #(
  parameter int              XLEN        = 32,
  parameter int              IMEM_WORDS  = 1024,
  parameter int              DMEM_WORDS  = 1024,
  parameter logic [XLEN-1:0] DMEM_BASE   = 32'h0001_0000,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h0000_F000,
  parameter int              RST_HOLD    = 4,
  parameter int unsigned     TIMEOUT     = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  core_rst_n,
  cpu_bringup_harness_if.slave  bus
);

  localparam int              IW           = $clog2(IMEM_WORDS);
  localparam int              DW           = $clog2(DMEM_WORDS);
  localparam int              HW           = $clog2(RST_HOLD + 1);
  localparam logic [XLEN-1:0] NOP          = XLEN'(32'h0000_0013);
  localparam logic [31:0]     TIMEOUT_LAST = 32'(TIMEOUT - 32'd1);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            core_rst_n_q, core_rst_n_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [XLEN-2:0] fail_code_q, fail_code_d;
  logic            timeout_q, timeout_d;
  logic            addr_err_q, addr_err_d;
  logic [31:0]     cycles_q, cycles_d;

  logic [XLEN-1:0] imem_q [IMEM_WORDS];
  logic [XLEN-1:0] dmem_q [DMEM_WORDS];

  logic [IW-1:0]   im_idx_s;
  logic [IW-1:0]   ld_idx_s;
  logic [DW-1:0]   dm_idx_s;
  logic [XLEN-1:0] dm_off_s;
  logic            im_in_s;
  logic            ld_in_s;
  logic            dm_in_s;
  logic            tohost_s;
  logic            imem_we_s;
  logic            dmem_we_s;
  logic            unused_s;

  // Subtracting the base lets addresses below DMEM_BASE wrap high and fail the range test.
  assign dm_off_s = bus.addr - DMEM_BASE;
  assign dm_in_s  = (dm_off_s[XLEN-1:DW+2] == '0);
  assign dm_idx_s = dm_off_s[DW+1:2];
  assign im_in_s  = (bus.iaddr[XLEN-1:IW+2] == '0);
  assign im_idx_s = bus.iaddr[IW+1:2];
  assign ld_in_s  = (bus.ld_addr[XLEN-1:IW+2] == '0);
  assign ld_idx_s = bus.ld_addr[IW+1:2];
  assign tohost_s = (bus.addr == TOHOST_ADDR);
  assign unused_s = ^{bus.iaddr[1:0], bus.ld_addr[1:0], dm_off_s[1:0]};

  // Zero-latency instruction fetch and data load.
  always_comb begin
    bus.idata = NOP;
    bus.data  = '0;
    if (im_in_s) begin
      bus.idata = imem_q[im_idx_s];
    end else begin
      bus.idata = NOP;
    end
    if (dm_in_s) begin
      bus.data = dmem_q[dm_idx_s];
    end else begin
      bus.data = '0;
    end
  end

  // Sequencer next-state and status update.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    core_rst_n_d = core_rst_n_q;
    done_d       = done_q;
    pass_d       = pass_q;
    fail_code_d  = fail_code_q;
    timeout_d    = timeout_q;
    addr_err_d   = addr_err_q;
    cycles_d     = cycles_q;
    imem_we_s    = 1'b0;
    dmem_we_s    = 1'b0;
    case (state_q)
      ST_HOLD, ST_DONE: begin
        if (bus.ld_en) begin
          if (ld_in_s) begin
            imem_we_s = 1'b1;
          end else begin
            addr_err_d = 1'b1;
          end
        end else begin
          imem_we_s = 1'b0;
        end
        if (state_q == ST_HOLD) begin
          if (hold_q == HW'(RST_HOLD)) begin
            state_d      = ST_RUN;
            core_rst_n_d = 1'b1;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end else begin
          core_rst_n_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (cycles_q != 32'hFFFF_FFFF) begin
          cycles_d = cycles_q + 32'd1;
        end else begin
          cycles_d = cycles_q;
        end
        if (!im_in_s || (!dm_in_s && !tohost_s)) begin
          addr_err_d = 1'b1;
        end else begin
          addr_err_d = addr_err_q;
        end
        dmem_we_s = bus.wr && dm_in_s;
        // A tohost write beats a timeout landing in the same cycle.
        if (bus.wr && tohost_s) begin
          state_d      = ST_DONE;
          core_rst_n_d = 1'b0;
          done_d       = 1'b1;
          pass_d       = (bus.wdata == XLEN'(1));
          fail_code_d  = bus.wdata[XLEN-1:1];
        end else if ((TIMEOUT != 0) && (cycles_q == TIMEOUT_LAST)) begin
          state_d      = ST_DONE;
          core_rst_n_d = 1'b0;
          done_d       = 1'b1;
          pass_d       = 1'b0;
          timeout_d    = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d      = ST_HOLD;
        core_rst_n_d = 1'b0;
      end
    endcase
  end

  // Sequencer and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HOLD;
      hold_q       <= '0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_code_q  <= '0;
      timeout_q    <= 1'b0;
      addr_err_q   <= 1'b0;
      cycles_q     <= 32'd0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      core_rst_n_q <= core_rst_n_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_code_q  <= fail_code_d;
      timeout_q    <= timeout_d;
      addr_err_q   <= addr_err_d;
      cycles_q     <= cycles_d;
    end
  end

  // Memories are deliberately unreset so a loaded program survives rst_n pulses.
  always_ff @(posedge clk) begin
    if (imem_we_s) begin
      imem_q[ld_idx_s] <= bus.ld_data;
    end
    if (dmem_we_s) begin
      dmem_q[dm_idx_s] <= bus.wdata;
    end
  end

  assign core_rst_n    = core_rst_n_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_code = fail_code_q;
  assign bus.timeout   = timeout_q;
  assign bus.addr_err  = addr_err_q;
  assign bus.cycles    = cycles_q;

endmodule
